// File: rtl/systolic_ctrl.sv
// Sequencer for an ARRAY_DIM x ARRAY_DIM output-stationary systolic array: clear, skewed feed, drain.
// Optional cycle counter output perf_cycles is enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_ctrl #(
  parameter int ARRAY_DIM  = 4,
  parameter int K_WIDTH    = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [K_WIDTH-1:0]           k_len,
  output logic                         busy,
  output logic                         done,
  output logic                         pe_clear,
  output logic                         pe_enable,
  output logic                         a_rd_en,
  output logic [ADDR_WIDTH-1:0]        a_rd_addr,
  output logic                         b_rd_en,
  output logic [ADDR_WIDTH-1:0]        b_rd_addr,
  output logic [ARRAY_DIM-1:0]         row_feed_valid,
  output logic [ARRAY_DIM-1:0]         col_feed_valid,
  output logic                         res_valid,
  output logic [$clog2(ARRAY_DIM)-1:0] res_row
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,output logic [31:0]                 perf_cycles
`endif
);

  localparam int ROW_W = $clog2(ARRAY_DIM);
  localparam int CNT_W = K_WIDTH + ROW_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [K_WIDTH-1:0]  k_q, k_d;
  logic [CNT_W-1:0]    t_q, t_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [CNT_W-1:0]    k_ext_q, k_ext_d, t_last;

  assign k_ext_q = CNT_W'(k_q);
  assign k_ext_d = CNT_W'(k_d);
  assign t_last  = k_ext_q + CNT_W'(2 * ARRAY_DIM - 2);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d     = k_len;
          state_d = (k_len == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        t_d     = '0;
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (t_q == t_last) begin
          row_d   = '0;
          state_d = S_DRAIN;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (row_q == ROW_W'(ARRAY_DIM - 1)) state_d = S_DONE;
        else                                row_d   = row_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so that every output is a flop.
  logic                  busy_d, done_d, clear_d, enable_d, rd_en_d, res_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ARRAY_DIM-1:0]  feed_d, feed_q;
  logic                  busy_q, done_q, clear_q, enable_q, rd_en_q, res_valid_q;
  logic [ROW_W-1:0]      res_row_q;

  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    clear_d     = (state_d == S_CLEAR);
    enable_d    = (state_d == S_COMPUTE);
    rd_en_d     = (state_d == S_COMPUTE) && (t_d < k_ext_d);
    res_valid_d = (state_d == S_DRAIN);
    addr_d      = rd_en_d ? ADDR_WIDTH'(t_d[K_WIDTH-1:0]) : addr_q;
  end

  // Row/column i sees its first operand i cycles late because of the systolic skew.
  for (genvar gi = 0; gi < ARRAY_DIM; gi++) begin : g_feed
    assign feed_d[gi] = (state_d == S_COMPUTE) &&
                        (t_d >= CNT_W'(gi + 1)) &&
                        (t_d <= CNT_W'(gi) + k_ext_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      t_q         <= '0;
      row_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clear_q     <= 1'b0;
      enable_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      res_valid_q <= 1'b0;
      addr_q      <= '0;
      feed_q      <= '0;
      res_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      t_q         <= t_d;
      row_q       <= row_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      clear_q     <= clear_d;
      enable_q    <= enable_d;
      rd_en_q     <= rd_en_d;
      res_valid_q <= res_valid_d;
      addr_q      <= addr_d;
      feed_q      <= feed_d;
      res_row_q   <= row_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pe_clear       = clear_q;
  assign pe_enable      = enable_q;
  assign a_rd_en        = rd_en_q;
  assign b_rd_en        = rd_en_q;
  assign a_rd_addr      = addr_q;
  assign b_rd_addr      = addr_q;
  assign row_feed_valid = feed_q;
  assign col_feed_valid = feed_q;
  assign res_valid      = res_valid_q;
  assign res_row        = res_row_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE && start)    perf_d = '0;
    else if (busy_q && perf_q != '1)   perf_d = perf_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for an ARRAY_DIM x ARRAY_DIM output-stationary systolic array of pe instances.
  - Each pe has an 8-bit a/b input, a 32-bit accumulator, and forwards a_out/b_out.
- Accepts a start request and generates read addresses for the A-row and B-column operand buffers.
- Produces the per-row/per-column skewed feed-valid masks, the global PE enable and the accumulator clear, then drains results row by row.
- Sits between the top-level command interface and the array plus its operand buffers.

Parameters:
- ARRAY_DIM, 4, PE rows = PE columns (N); minimum 2.
- K_WIDTH, 8, width of the inner-dimension length k_len.
- ADDR_WIDTH, 8, operand buffer address width; must be >= K_WIDTH.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  start request, sampled only in IDLE.
- k_len  in  K_WIDTH  inner dimension length, latched with start.
- busy  out  1  high from the cycle after start acceptance until DONE, inclusive.
- done  out  1  one-cycle completion pulse.
- pe_clear  out  1  synchronous clear of all PE accumulators.
- pe_enable  out  1  global enable to all PEs.
- a_rd_en  out  1  A buffer read strobe.
- a_rd_addr  out  ADDR_WIDTH  A buffer address.
- b_rd_en  out  1  B buffer read strobe.
- b_rd_addr  out  ADDR_WIDTH  B buffer address.
- row_feed_valid  out  ARRAY_DIM  bit i: row i's left-edge input carries valid A data; otherwise the array injects zero.
- col_feed_valid  out  ARRAY_DIM  bit j: column j's top-edge input carries valid B data.
- res_valid  out  1  result row is presented on the array result mux.
- res_row  out  $clog2(ARRAY_DIM)  result row index.

Behaviour:
- Reset: state=IDLE; every output 0; internal counters 0. Reset mid-operation aborts immediately and performs no done pulse.
- FSM states: IDLE, CLEAR, COMPUTE, DRAIN, DONE.
- IDLE:
  - start=1 latches k_len.
  - If k_len==0, go to DONE; otherwise go to CLEAR.
  - start while not IDLE is ignored, with no queuing.
- CLEAR: exactly 1 cycle; pe_clear=1; go to COMPUTE.
- COMPUTE: cycle counter t runs from 0 to T-1, where T = k_len + 2*ARRAY_DIM - 1.
  - pe_enable=1 for all T cycles.
  - a_rd_en=b_rd_en=1 only for t < k_len, with a_rd_addr=b_rd_addr=t (zero-extended). Addresses hold their last value afterwards; rd_en=0.
  - Operand buffers have 1-cycle read latency.
  - row_feed_valid[i]=1 iff 1+i <= t <= i+k_len; col_feed_valid[j] follows the same rule with j.
  - At t==T-1, go to DRAIN.
  - The counter is K_WIDTH+$clog2(ARRAY_DIM)+1 bits, so there is no overflow at k_len = 2^K_WIDTH-1.
- DRAIN: ARRAY_DIM cycles; pe_enable=0; res_valid=1; res_row = 0..ARRAY_DIM-1 in order; go to DONE.
- DONE: 1 cycle; done=1, busy=1; return to IDLE. A new start is accepted in the following IDLE cycle.
- All outputs are registered; no combinational path from start or k_len to any output.
- Ordering: pe_clear and pe_enable are never high in the same cycle.

Optional Feature:
- Macro: SYSTOLIC_CTRL_PERF_EN.
- Defined:
  - Adds output perf_cycles (32 bits).
  - Cleared on start acceptance; increments every cycle while busy=1.
  - Holds its value after done until the next start.
  - Saturates at 0xFFFFFFFF.
  - Reset value is 0.
- Undefined: the port and the counter do not exist; behaviour is otherwise identical.

Test Plan:
- ARRAY_DIM=4, k_len=4, start at cycle 0 ->
  - pe_clear high in cycle 1.
  - pe_enable high for cycles 2..12 (11 cycles).
  - a_rd_addr = 0,1,2,3 in cycles 2..5.
  - row_feed_valid[0] high in cycles 3..6 and row_feed_valid[3] high in cycles 6..9.
  - res_valid in cycles 13..16 with res_row 0..3.
  - done in cycle 17.
- k_len=0 -> no pe_clear and no pe_enable; busy and done high in cycle 1; IDLE in cycle 2.
- start pulsed again during COMPUTE with a different k_len -> ignored; pe_enable count remains the first k_len+7.
- k_len=255 (K_WIDTH=8) -> pe_enable high for exactly 262 cycles; final a_rd_addr=254; no counter wrap.
- rst_n asserted mid-COMPUTE (t=5) -> all outputs 0 asynchronously; no done; after release, a new start runs a full, correct sequence.
- With SYSTOLIC_CTRL_PERF_EN, k_len=4, ARRAY_DIM=4 -> perf_cycles=17 after done, held until the next start.
